step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter M, default 12_000_000, clk cycles per step (M >= 1).
REQ-002 SHALL have parameter AW, default 4, address width in bits.
REQ-003 SHALL have parameter LAST, default 15, final address of a pass (LAST <= 2^AW-1).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge; one clock domain only.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  level, sampled each edge; begins a pass when idle.
REQ-007 SHALL have port stop  input  1  level, sampled each edge; aborts a pass.
REQ-008 SHALL have port loop  input  1  level; when sampled high at end of the final step, the sequence wraps to address 0 instead of finishing.
REQ-009 SHALL have port addr  output  AW  current step address (e.g. ROM address), registered.
REQ-010 SHALL have port step  output  1  one-cycle pulse marking the first cycle each address is valid.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse after a non-looping pass completes.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-014 SHALL contain a modulo-M cycle counter of width max(1, clog2(M)), held at 0 outside RUN.
REQ-015 IDLE: start=1 and stop=0 sampled -> RUN next cycle with counter=0, addr=0.
REQ-016 IDLE: start=1 and stop=1 in the same cycle -> remain IDLE (stop wins).
REQ-017 RUN: counter counts 0..M-1 and wraps to 0; step = (state==RUN && counter==0), combinational decode.
REQ-018 RUN, counter==M-1, addr<LAST -> addr increments by 1.
REQ-019 RUN, counter==M-1, addr==LAST, loop=1 -> addr=0, stay RUN, no done.
REQ-020 RUN, counter==M-1, addr==LAST, loop=0 -> DONE; addr holds LAST during DONE.
REQ-021 DONE lasts exactly one cycle, then IDLE with addr=0.
REQ-022 RUN: stop=1 sampled -> IDLE next cycle, addr=0, counter=0, no done pulse; stop takes priority over the end-of-pass transitions in REQ-019/REQ-020.
REQ-023 start SHALL be ignored in RUN and DONE; a new pass requires start sampled in IDLE.
REQ-024 Timing: start sampled at edge t -> step at cycles t+1+kM for k=0..LAST, addr=k from t+1+kM to t+(k+1)M, done at cycle t+1+(LAST+1)M.
REQ-025 M=1: step high every RUN cycle; addr advances every cycle.
REQ-026 LAST=0: single step per pass; done follows after M cycles unless loop=1.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state=IDLE, counter=0, addr=0, step=0, busy=0, done=0.
REQ-028 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release the block waits in IDLE for start.

Verification (M=4, AW=3, LAST=3; start pulsed one cycle, sampled at edge 0)
REQ-029 Single pass, loop=0 -> step at cycles 1,5,9,13 with addr 0,1,2,3; busy high cycles 1-16; done high only at cycle 17; addr=0, idle from cycle 18.
REQ-030 loop=1 throughout -> step at cycle 17 with addr=0, no done; loop dropped at cycle 20 -> done at cycle 33.
REQ-031 stop=1 at cycle 6 -> IDLE at cycle 7, addr=0, busy=0, no done; start at cycle 7 sampled -> step at cycle 8, addr=0.
REQ-032 start re-pulsed at cycle 3 -> ignored, timing identical to REQ-029; start=stop=1 in IDLE -> busy stays 0.
REQ-033 rst asserted mid-cycle 10 -> all outputs 0 before next edge; released at 12 -> idle until start.
REQ-034 M=1 instance, LAST=3 -> step at cycles 1-4, addr 0-3, done at cycle 5.

Source files
------------

// File: rtl/step_sequencer.sv
// Step sequencer: walks an address from 0 to LAST, holding each address for M clock cycles.
// Optionally loops back to 0 at the end of a pass; otherwise pulses done for one cycle.
module step_sequencer #(
    parameter int unsigned M    = 12_000_000,
    parameter int unsigned AW   = 4,
    parameter int unsigned LAST = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic [AW-1:0] addr,
    output logic          step,
    output logic          busy,
    output logic          done
);

    localparam int unsigned    CW       = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0]  CntMax   = CW'(M - 1);
    localparam logic [AW-1:0]  AddrLast = AW'(LAST);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // stop outranks every end-of-pass decision
                if (stop) begin
                    state_d = StIdle;
                    addr_d  = '0;
                end else if (cnt_q == CntMax) begin
                    if (addr_q < AddrLast) begin
                        addr_d = addr_q + AW'(1);
                    end else if (loop) begin
                        addr_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = '0;
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        addr = addr_q;
        busy = (state_q == StRun);
        done = (state_q == StDone);
        step = (state_q == StRun) && (cnt_q == '0);
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: expected step/done events are queued by the stimulus
// and matched by per-instance monitors; M=4/LAST=3 and M=1/LAST=3 instances.
module tb_step_sequencer;

    localparam int M    = 4;
    localparam int AW   = 3;
    localparam int LAST = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
    logic          start_b = 1'b0;
    logic [AW-1:0] addr_a, addr_b;
    logic          step_a, busy_a, done_a;
    logic          step_b, busy_b, done_b;

    step_sequencer #(.M(M), .AW(AW), .LAST(LAST)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .stop  (stop_a),
        .loop  (loop_a),
        .addr  (addr_a),
        .step  (step_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    step_sequencer #(.M(1), .AW(AW), .LAST(LAST)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .stop  (1'b0),
        .loop  (1'b0),
        .addr  (addr_b),
        .step  (step_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int addr;
        int cyc;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    function automatic void check(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endfunction

    function automatic void push_a(bit d, int a, int c);
        ev_t e;
        e.is_done = d;
        e.addr    = a;
        e.cyc     = c;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(bit d, int a, int c);
        ev_t e;
        e.is_done = d;
        e.addr    = a;
        e.cyc     = c;
        q_b.push_back(e);
    endfunction

    // Full pass on instance A whose first step appears at cycle 'first'.
    function automatic void pass_a(int first, bit with_done);
        for (int k = 0; k <= LAST; k++) push_a(1'b0, k, first + k * M);
        if (with_done) push_a(1'b1, LAST, first + (LAST + 1) * M);
    endfunction

    always @(negedge clk) begin
        if (step_a || done_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = q_a.pop_front();
                check("a_done", int'(done_a), int'(e.is_done));
                check("a_step", int'(step_a), int'(!e.is_done));
                check("a_addr", int'(addr_a), e.addr);
                check("a_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (step_b || done_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = q_b.pop_front();
                check("b_done", int'(done_b), int'(e.is_done));
                check("b_step", int'(step_b), int'(!e.is_done));
                check("b_addr", int'(addr_b), e.addr);
                check("b_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        int exp_addr;

        #1;
        check("rst_addr", int'(addr_a), 0);
        check("rst_step", int'(step_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // M=1: one step per cycle, done right after
        @(negedge clk);
        c = cyc;
        start_b = 1'b1;
        for (int k = 0; k <= LAST; k++) push_b(1'b0, k, c + 1 + k);
        push_b(1'b1, LAST, c + LAST + 2);
        @(negedge clk);
        start_b = 1'b0;
        repeat (8) @(negedge clk);
        check("b_queue_empty", q_b.size(), 0);

        // single pass, start re-pulsed at cycle 3 must be ignored
        @(negedge clk);
        c = cyc;
        start_a = 1'b1;
        pass_a(c + 1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start_a = (i == 3);
            if (i <= 16) exp_addr = (i - 1) / M;
            else if (i == 17) exp_addr = LAST;
            else exp_addr = 0;
            check("s1_busy", int'(busy_a), int'(i <= 16));
            check("s1_addr", int'(addr_a), exp_addr);
        end
        start_a = 1'b0;
        check("s1_queue_empty", q_a.size(), 0);

        // start and stop together in idle: stop wins
        start_a = 1'b1;
        stop_a  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("both_busy", int'(busy_a), 0);
        end
        start_a = 1'b0;
        stop_a  = 1'b0;

        // loop: wrap at cycle 17, loop dropped at cycle 20, done at 33
        @(negedge clk);
        c = cyc;
        start_a = 1'b1;
        loop_a  = 1'b1;
        pass_a(c + 1, 1'b0);
        pass_a(c + 17, 1'b1);
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (i == 20) loop_a = 1'b0;
        end
        check("loop_queue_empty", q_a.size(), 0);

        // stop at cycle 6, restart at cycle 7
        @(negedge clk);
        c = cyc;
        start_a = 1'b1;
        push_a(1'b0, 0, c + 1);
        push_a(1'b0, 1, c + 5);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (i == 6) stop_a = 1'b1;
        end
        @(negedge clk);
        stop_a = 1'b0;
        check("stop_busy", int'(busy_a), 0);
        check("stop_addr", int'(addr_a), 0);
        check("stop_done", int'(done_a), 0);
        start_a = 1'b1;
        pass_a(c + 8, 1'b1);
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        check("stop_queue_empty", q_a.size(), 0);

        // async reset in the middle of cycle 10, released at cycle 12
        @(negedge clk);
        c = cyc;
        start_a = 1'b1;
        push_a(1'b0, 0, c + 1);
        push_a(1'b0, 1, c + 5);
        push_a(1'b0, 2, c + 9);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_addr", int'(addr_a), 0);
        check("arst_step", int'(step_a), 0);
        check("arst_busy", int'(busy_a), 0);
        check("arst_done", int'(done_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_busy", int'(busy_a), 0);
        end
        check("rst_queue_empty", q_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
